// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a valid/ready byte stream into 16-bit words for the
// downstream bit/byte extraction stage, along with a rolling 4-bit bit-select
// index and a delivered-word count. A flush closes a half-filled word with
// PAD_BYTE.
//
// Optional feature: define WORD_PACK_PARITY_EN to add output out_parity, the
// XOR of all 16 data bits, registered alongside data.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its payload steady until the
// transfer; valid never drops without one. in_ready depends combinationally on
// out_ready so that a word can leave and a new byte can enter on the same edge.
module byte_word_packer #(
    parameter bit         UPPER_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] data,
    output logic [3:0]  sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        partial,
    output logic [7:0]  word_count
`ifdef WORD_PACK_PARITY_EN
    ,
    output logic        out_parity
`endif
);

    // EMPTY: no byte held. HALF: first byte held. FULL: word waiting downstream.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Kept as a named, typed register so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic [7:0]  hold_byte;
    logic        accept;
    logic        deliver;
    logic        load_word;
    logic        load_partial;
    logic [15:0] word_next;

    // Places the first and second byte of a pair according to UPPER_FIRST.
    function automatic logic [15:0] form_word(input logic [7:0] first,
                                              input logic [7:0] second);
        if (UPPER_FIRST)
            return {first, second};
        else
            return {second, first};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    // Next-state logic; flush only matters in HALF and loses to a real byte.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (accept) state_next = HALF;
            HALF:  if (accept || flush) state_next = FULL;
            FULL:  if (deliver) state_next = accept ? HALF : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output and handshake decode, including what the next word will be.
    always_comb begin
        out_valid    = (state == FULL);
        in_ready     = (state != FULL) || out_ready;
        accept       = in_valid && in_ready;
        deliver      = out_valid && out_ready;
        load_word    = (state == HALF) && (accept || flush);
        load_partial = (state == HALF) && !accept && flush;
        word_next    = form_word(hold_byte, load_partial ? PAD_BYTE : in_byte);
    end

    // Datapath: hold the first byte, capture the formed word, step counters on delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_byte  <= 8'h00;
            data       <= 16'h0000;
            partial    <= 1'b0;
            sel        <= 4'd0;
            word_count <= 8'd0;
`ifdef WORD_PACK_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            // A byte entering EMPTY, or FULL while the word leaves, starts a new pair.
            if (accept && state != HALF)
                hold_byte <= in_byte;
            if (load_word) begin
                data    <= word_next;
                partial <= load_partial;
`ifdef WORD_PACK_PARITY_EN
                out_parity <= ^word_next;
`endif
            end
            // The index advances only at delivery, so the next word carries the new value.
            if (deliver) begin
                sel        <= sel + 4'd1;
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: two instances share one byte stream, one with
// UPPER_FIRST=1/PAD_BYTE=00 and one with UPPER_FIRST=0/PAD_BYTE=A5.
// Expected pairs are pushed when the driver sees a byte or flush accepted and
// popped when a word is delivered.
module tb_byte_word_packer;

    localparam logic [7:0] PAD_U = 8'h00;
    localparam logic [7:0] PAD_L = 8'hA5;

    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready_u, in_ready_l;
    logic [15:0] data_u, data_l;
    logic [3:0]  sel_u, sel_l;
    logic        out_valid_u, out_valid_l;
    logic        partial_u, partial_l;
    logic [7:0]  word_count_u, word_count_l;
`ifdef WORD_PACK_PARITY_EN
    logic        parity_u, parity_l;
`endif

    int checks   = 0;
    int failures = 0;

    // {partial, sel[3:0], first[7:0], second[7:0]}
    logic [20:0] exp_q[$];

    // driver-side reference model
    bit          has_half;
    logic [7:0]  first_byte;
    int          words_formed;
    // monitor-side delivery counter
    int          deliveries;

    byte_word_packer #(.UPPER_FIRST(1'b1), .PAD_BYTE(PAD_U)) u_upper (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready_u), .flush(flush), .data(data_u), .sel(sel_u),
        .out_valid(out_valid_u), .out_ready(out_ready), .partial(partial_u),
        .word_count(word_count_u)
`ifdef WORD_PACK_PARITY_EN
        , .out_parity(parity_u)
`endif
    );

    byte_word_packer #(.UPPER_FIRST(1'b0), .PAD_BYTE(PAD_L)) u_lower (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready_l), .flush(flush), .data(data_l), .sel(sel_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .partial(partial_l),
        .word_count(word_count_l)
`ifdef WORD_PACK_PARITY_EN
        , .out_parity(parity_l)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        has_half     = 1'b0;
        first_byte   = 8'h00;
        words_formed = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (has_half) begin
            exp_q.push_back({1'b0, words_formed[3:0], first_byte, b});
            words_formed++;
            has_half = 1'b0;
        end else begin
            first_byte = b;
            has_half   = 1'b1;
        end
    endtask

    // drive one byte and hold it until accepted, bounded by a cycle budget
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_byte  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready_u) begin
                model_accept(b);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // one-cycle flush pulse; only a half word with no byte this cycle is closed
    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        if (has_half && !in_valid) begin
            exp_q.push_back({1'b1, words_formed[3:0], first_byte, 8'h00});
            words_formed++;
            has_half = 1'b0;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // scoreboard: compare each delivered word against the oldest expectation
    initial begin
        logic [20:0] e;
        logic [7:0]  sec_u, sec_l;
        logic [15:0] exp_u, exp_l;
        deliveries = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                deliveries = 0;
            end else if (out_valid_u && out_ready) begin
                deliveries++;
                chk("valid_agree", {31'd0, out_valid_l}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, data_u}, 32'd0);
                end else begin
                    e     = exp_q.pop_front();
                    sec_u = e[20] ? PAD_U : e[7:0];
                    sec_l = e[20] ? PAD_L : e[7:0];
                    exp_u = {e[15:8], sec_u};
                    exp_l = {sec_l, e[15:8]};
                    chk("data_upper", {16'd0, data_u}, {16'd0, exp_u});
                    chk("data_lower", {16'd0, data_l}, {16'd0, exp_l});
                    chk("sel", {28'd0, sel_u}, {28'd0, e[19:16]});
                    chk("partial", {31'd0, partial_u}, {31'd0, e[20]});
                    chk("partial_lower", {31'd0, partial_l}, {31'd0, e[20]});
`ifdef WORD_PACK_PARITY_EN
                    chk("parity_upper", {31'd0, parity_u}, {31'd0, ^exp_u});
                    chk("parity_lower", {31'd0, parity_l}, {31'd0, ^exp_l});
`endif
                end
            end
        end
    end

    initial begin
        int stall_sel;
        rst       = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_data", {16'd0, data_u}, 32'd0);
        chk("rst_sel", {28'd0, sel_u}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
        chk("rst_partial", {31'd0, partial_u}, 32'd0);
        chk("rst_word_count", {24'd0, word_count_u}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_u}, 32'd1);
        @(posedge clk);
        #1;

        // basic pack and byte order
        send_byte(8'hAB);
        send_byte(8'hCD);
        idle(2);
        @(negedge clk);
        chk("sel_after_first", {28'd0, sel_u}, 32'd1);
        chk("count_after_first", {24'd0, word_count_u}, 32'd1);
        @(posedge clk);
        #1;
        send_byte(8'h12);
        send_byte(8'h34);

        // parity patterns 0001 / 0003
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h03);
        idle(2);

        // backpressure: word held while out_ready is low
        out_ready = 1'b0;
        send_byte(8'h5A);
        send_byte(8'h5A);
        stall_sel = words_formed - 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready_u}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid_u}, 32'd1);
            chk("stall_data", {16'd0, data_u}, 32'h5A5A);
            chk("stall_sel", {28'd0, sel_u}, stall_sel & 32'hF);
            @(posedge clk);
            #1;
        end
        do_flush();   // ignored while FULL
        @(negedge clk);
        chk("flush_full_data", {16'd0, data_u}, 32'h5A5A);
        chk("flush_full_partial", {31'd0, partial_u}, 32'd0);
        @(posedge clk);
        #1;
        // release: delivery and new byte accept on the same edge
        out_ready = 1'b1;
        send_byte(8'h77);
        send_byte(8'h88);
        idle(2);

        // flush closes a half word
        send_byte(8'hEE);
        do_flush();
        idle(2);
        // flush in EMPTY does nothing
        do_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_empty_valid", {31'd0, out_valid_u}, 32'd0);
            @(posedge clk);
            #1;
        end
        // flush together with a byte accept: normal word
        send_byte(8'h41);
        flush = 1'b1;
        send_byte(8'h42);
        flush = 1'b0;
        idle(2);

        // reset mid-word discards the held byte
        send_byte(8'h99);
        do_reset();
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid_u}, 32'd0);
        chk("midrst_sel", {28'd0, sel_u}, 32'd0);
        chk("midrst_word_count", {24'd0, word_count_u}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready_u}, 32'd1);
        @(posedge clk);
        #1;
        send_byte(8'h10);
        send_byte(8'h20);
        idle(2);

        // wrap: exactly 256 words from a clean start
        do_reset();
        for (int w = 0; w < 256; w++) begin
            send_byte(8'($urandom_range(0, 255)));
            send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        @(negedge clk);
        chk("wrap_word_count", {24'd0, word_count_u}, 32'd0);
        chk("wrap_word_count_lower", {24'd0, word_count_l}, 32'd0);
        chk("wrap_sel", {28'd0, sel_u}, 32'd0);
        chk("wrap_deliveries", deliveries, 32'd256);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Packs a byte stream into 16-bit words for the downstream bit/byte extraction stage.
- Drives that stage's 16-bit data word and its 4-bit bit-select index.
- Upstream uses a valid/ready byte interface; downstream uses a valid/ready word interface.
- A flush input closes a half-filled word with a pad byte.

Parameters:
- UPPER_FIRST, 1: 1 = first byte of a pair lands in data[15:8]; 0 = first byte lands in data[7:0].
- PAD_BYTE, 8'h00: byte value used to fill the missing half on flush.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_byte  input  8  incoming byte
- in_valid  input  1  in_byte is valid
- in_ready  output  1  packer accepts in_byte this cycle
- flush  input  1  pad and emit any half-filled word
- data  output  16  packed word to downstream stage
- sel  output  4  bit-select index for downstream stage
- out_valid  output  1  data/sel/partial are valid
- out_ready  input  1  downstream accepts word this cycle
- partial  output  1  current word was completed by flush
- word_count  output  8  count of words delivered

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state EMPTY, data=16'h0000, sel=0, out_valid=0, partial=0, word_count=0, internal hold byte=0. in_ready=1 immediately after reset.
- Handshakes:
  - Byte accepted when in_valid && in_ready.
  - Word delivered when out_valid && out_ready.
- in_ready = (state != FULL) || out_ready. This is combinational from out_ready, giving one byte per cycle sustained.
- States:
  - EMPTY: byte accepted -> hold byte, go to HALF.
  - HALF: second byte accepted -> form word, go to FULL, out_valid=1 next cycle. Latency: second byte accepted at edge N, word valid from edge N, visible cycle N+1.
  - HALF, flush=1, no byte accepted this cycle -> form word with PAD_BYTE in the missing half, partial=1, go to FULL.
  - FULL, delivered, no byte accepted -> EMPTY.
  - FULL, delivered, byte accepted same cycle -> HALF holding that byte.
  - FULL, not delivered -> stay. data, sel and partial are held stable; in_ready=0.
- Word forming:
  - UPPER_FIRST=1: data = {first, second}.
  - UPPER_FIRST=0: data = {second, first}.
  - Flush fills the "second" slot with PAD_BYTE.
- Full word completed normally: partial=0.
- On each word delivery:
  - sel increments by 1, wrapping 15->0 (mod 16). sel changes only at delivery, so the next word carries the new index.
  - word_count increments by 1, wrapping 255->0.
- Flush corner cases:
  - flush in EMPTY or FULL: ignored, no state change.
  - flush in HALF with a byte accepted the same cycle: byte wins; word completes normally, partial=0.
- out_valid never drops without a delivery handshake.
- rst asserted mid-word (HALF or FULL): the held byte and the pending word are discarded, all outputs return to reset values next edge.

Optional Feature:
- Macro WORD_PACK_PARITY_EN.
- Defined:
  - Extra output port out_parity (1 bit) = XOR of all 16 bits of data.
  - Registered together with data, reset 0, held stable while stalled.
  - A flushed word's parity includes PAD_BYTE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic pack, UPPER_FIRST=1: bytes 8'hAB then 8'hCD, out_ready=1 -> data=16'hABCD, sel=0, partial=0 one cycle after second accept; then sel=1, word_count=1.
- Byte order, UPPER_FIRST=0: bytes 8'h12, 8'h34 -> data=16'h3412.
- Backpressure: word 16'h5A5A pending with out_ready=0 for 5 cycles -> in_ready=0, data/sel stable; release with in_valid=1, in_byte=8'h77 -> word delivered and 8'h77 held, state HALF, same cycle.
- Flush: byte 8'hEE, then flush=1 with in_valid=0, PAD_BYTE=8'h00 -> data=16'hEE00, partial=1.
  - flush asserted in EMPTY -> no out_valid.
  - flush together with a byte accept in HALF -> normal word, partial=0.
- Wrap: deliver 16 words -> sel sequence 0..15 then 0; after 256 words word_count=0.
- Reset mid-operation: rst while HALF holding 8'h99 -> next word after reset built only from new bytes; sel=0, word_count=0. With WORD_PACK_PARITY_EN: 16'h0001 -> out_parity=1, 16'h0003 -> out_parity=0.
